// File: rtl/display_pkg.sv
// Shared constants and types for the steps-per-minute display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [15:0] BCD_MAX    = 16'd9999;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_COMMIT
  } state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 4-digit BCD, one iteration per cycle.
// done marks the cycle whose edge completes the final iteration; bcd is valid from the next cycle.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [15:0] shreg;
  logic [3:0]  cnt;
  logic        running;
  logic [15:0] adj;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      shreg   <= bin;
      bcd     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      {bcd, shreg} <= {adj[14:0], shreg, 1'b0};
      cnt          <= cnt + 4'd1;
      if (cnt == 4'd15) running <= 1'b0;
    end
  end

  assign done = running && (cnt == 4'd15);

endmodule

// File: rtl/spm_display.sv
// Captures a saturated SPM value, converts it to BCD and scans it onto a
// 4-digit active-low seven-segment display with leading-zero blanking.
module spm_display
  import display_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIG_DIV = CLK_HZ / (4 * REFRESH_HZ);
  localparam int TW      = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;

  state_t      state, state_nx;
  logic [15:0] load_sat;
  logic        load_ovf;
  logic [15:0] pend_val;
  logic        pend_ovf;
  logic        pend;
  logic        cur_ovf;
  logic [15:0] disp;
  logic        cv_start, take_pend, cv_done;
  logic [15:0] cv_bin, cv_bcd;

  always_comb begin
    load_ovf = (value > BCD_MAX);
    load_sat = load_ovf ? BCD_MAX : value;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (load || pend) state_nx = ST_CONV;
      ST_CONV:   if (cv_done)      state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = pend ? ST_CONV : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // A fresh load in IDLE supersedes anything pending; COMMIT chains into the pending value.
  always_comb begin
    busy      = (state != ST_IDLE);
    cv_start  = 1'b0;
    take_pend = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cv_start  = load || pend;
        take_pend = !load && pend;
      end
      ST_COMMIT: begin
        cv_start  = pend;
        take_pend = pend;
      end
      default: ;
    endcase
  end

  assign cv_bin = take_pend ? pend_val : load_sat;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (cv_start),
    .bin   (cv_bin),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_val <= '0;
      pend_ovf <= 1'b0;
      cur_ovf  <= 1'b0;
      disp     <= '0;
      ovf      <= 1'b0;
    end else begin
      if (cv_start) begin
        cur_ovf <= take_pend ? pend_ovf : load_ovf;
        pend    <= 1'b0;
      end
      if (state == ST_COMMIT) begin
        disp <= cv_bcd;
        ovf  <= cur_ovf;
      end
      if (load && state != ST_IDLE) begin
        pend     <= 1'b1;
        pend_val <= load_sat;
        pend_ovf <= load_ovf;
      end
    end
  end

  logic [TW-1:0] tick;
  logic [1:0]    sel;
  logic [3:0]    digit;
  logic          blank;

  always_comb begin
    digit = disp[3:0];
    blank = 1'b0;
    unique case (sel)
      2'd0: digit = disp[3:0];
      2'd1: begin digit = disp[7:4];   blank = (disp[15:4]  == 12'd0); end
      2'd2: begin digit = disp[11:8];  blank = (disp[15:8]  == 8'd0);  end
      2'd3: begin digit = disp[15:12]; blank = (disp[15:12] == 4'd0);  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
      sel  <= '0;
      an   <= '1;
      seg  <= SEG_BLANK;
      dp   <= 1'b1;
    end else if (tick == TW'(DIG_DIV - 1)) begin
      tick <= '0;
      sel  <= sel + 2'd1;
      an   <= ~(4'b0001 << sel);
      seg  <= blank ? SEG_BLANK : seg_decode(digit);
      dp   <= !((sel == 2'd3) && ovf);
    end else begin
      tick <= tick + 1'b1;
    end
  end

endmodule

// File: doc/spm_display.md
# spm_display

Downstream consumer of the steps-per-minute value. Each time `load` strobes, it captures a 16-bit binary value, saturates it to 9999, and converts it to four BCD digits with a sequential double-dabble converter. It drives a time-multiplexed 4-digit, active-low seven-segment display with leading-zero blanking and an overflow indicator. It sits between the SPM calculator and the board display pins.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `REFRESH_HZ`, 1000, full-frame refresh rate. Digit period is `DIG_DIV = CLK_HZ/(4*REFRESH_HZ)` cycles, 25_000 at the defaults.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `value`  in  16  unsigned binary value to show; sampled only when `load`=1.
- `load`  in  1  one-cycle strobe requesting capture/convert.
- `busy`  out  1  conversion in progress.
- `ovf`  out  1  last committed value exceeded 9999.
- `an`  out  4  digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- **Capture:** on `load`, latch `sat = (value > 9999) ? 9999 : value` and `ovf_n = (value > 9999)`.
- **FSM:**
  - IDLE: `load` -> CONV, iteration counter = 0.
  - CONV: one double-dabble iteration per cycle (add 3 to any BCD nibble ≥5, then shift left one bit), 16 iterations -> COMMIT.
  - COMMIT: copy the BCD result into the display register `disp[15:0]`, set `ovf <= ovf_n`. If `pend`=1, go to CONV with the pending value and clear `pend`; otherwise go to IDLE.
- **Load while busy:** `load` in CONV/COMMIT does not disturb the running conversion. It overwrites the pending value and sets `pend`. Only the latest pending value is kept; there is no FIFO.
- **Display register:** `disp` changes only in COMMIT. The scan always shows the last committed value, never intermediates.
- **Scan:**
  - Tick counter counts 0..`DIG_DIV`-1. On wrap, a 2-bit `sel` increments mod 4 and outputs re-register.
  - `an = ~(4'b0001 << sel)`.
- **Leading-zero blanking:** digit `k` > 0 is blanked (`seg`=7'h7F) if it and every higher digit are 0. Digit 0 is never blanked.
- **Overflow indicator:** `dp` = 0 only when `sel`=3 and `ovf`=1; otherwise 1.

## Timing
- **Reset values:** `busy`=0, `ovf`=0, `an`=4'hF, `seg`=7'h7F, `dp`=1, `disp`=0, `pend`=0, `sel`=0, tick counter=0, FSM=IDLE.
- **First scan:** outputs go active at the first tick wrap (`DIG_DIV` cycles after reset release), showing "0" on digit 0 with digits 1–3 blanked.
- **Conversion latency:** with `load` sampled at edge t:
  - `busy` = 1 from t+1 through t+17.
  - `disp`/`ovf` are valid after edge t+17.
  - `busy` = 0 at t+18 unless `pend` was set.
- **Back-to-back:** with `pend` set, the second conversion starts directly from COMMIT. `busy` stays high and the second commit lands 17 cycles after the first.
- **Scan latency:** `an`/`seg`/`dp` are registered and reflect `disp` as of the tick edge. A new value appears on a given digit within ≤4·`DIG_DIV` cycles.
- **Reset mid-operation:** `rst` aborts any conversion, drops `pend`, and restores all reset values in the same cycle.

## Structure
- **Shared package `display_pkg`:**
  - `NUM_DIGITS`=4.
  - `BCD_MAX`=16'd9999.
  - Active-low seven-segment constants `SEG_0`..`SEG_9`: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
  - `SEG_BLANK`=7'b1111111.
- **Sub-module `bin2bcd_seq`:** start/done handshake; 16-bit binary in, 16-bit BCD out; 16 iterations.
- **Top level:** saturation, pending logic, COMMIT, and the scan/blanking logic.

## Test plan
All scenarios use sim parameters `CLK_HZ`=4000, `REFRESH_HZ`=100, giving `DIG_DIV`=10.

- **Reset:** hold `rst` 3 cycles -> `an`=4'hF, `seg`=7'h7F, `dp`=1, `busy`=0. After 10 cycles, `an`=4'b1110 with `seg`=SEG_0. Digits 1–3 show `SEG_BLANK` as they are scanned.
- **Normal value:** `load` with `value`=1234 -> `busy` high exactly 17 cycles. Scan shows 4,3,2,1 on `an`=1110,1101,1011,0111, `dp`=1 throughout.
- **Blanking:** `value`=7 -> `SEG_7` on digit 0, blank on digits 1–3. `value`=1005 -> digits show 5,0,0,1 (interior zeros not blanked).
- **Overflow:** `value`=65535 -> displays 9999, `ovf`=1, `dp`=0 only while `an`=4'b0111. A following `load` of 10000 still shows 9999 with `ovf`=1. A following `load` of 42 -> `ovf`=0.
- **Load while busy:** `load` 100, then `load` 77 at +5 and `load` 42 at +8 -> first commit shows 100 at +17, final display 42 at +34. `busy` high continuously over that window; 77 is never displayed.
- **Reset mid-conversion:** `load` 5555, assert `rst` at +9 -> `busy`=0, `disp`=0, `pend`=0. The next scan shows "0".
